dot_accumulate: RTL and testbench

- Multiply-accumulate stage directly upstream of the sigmoid activation block.
- Consumes a stream of (activation, weight) pairs and forms their dot product over ARGS pairs.
- Rounds and saturates the sum to signed Q8.8 and emits it on a stb/rdy handshake that drives the sigmoid arg_* port directly.
- One result per ARGS accepted pairs; the input stalls while a result is pending.

---
 rtl/dot_accumulate.sv | 99 +++++++++
 tb/tb_dot_accumulate.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dot_accumulate.sv
// Multiply-accumulate over ARGS (unsigned Q0.8 activation, signed Q8.8 weight) pairs,
// rounded and saturated to signed Q8.8 and presented on a stb/rdy result port.
module dot_accumulate #(
  parameter int ARGS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inp_stb,
  output logic        inp_rdy,
  input  logic [7:0]  inp_dat,
  input  logic [15:0] inp_wgt,
  output logic        res_stb,
  input  logic        res_rdy,
  output logic [15:0] res_dat
);

  localparam int CW = (ARGS > 1) ? $clog2(ARGS) : 1;

  typedef enum logic {ST_ACC, ST_OUT} state_t;

  state_t             state_q;
  logic signed [31:0] acc_q;
  logic signed [31:0] acc_d;
  logic [CW-1:0]      cnt_q;
  logic               inp_rdy_q;
  logic               res_stb_q;
  logic [15:0]        res_dat_q;

  logic signed [23:0] dat_ext;
  logic signed [23:0] wgt_ext;
  logic signed [23:0] prod;
  logic signed [31:0] rnd;
  logic signed [31:0] shifted;
  logic [15:0]        sat;
  logic               accept;
  logic               last;

  // 24-bit operands keep the 9x16 product exact: 255 * -32768 still fits in Q8.16.
  always_comb begin
    dat_ext = {16'b0, inp_dat};
    wgt_ext = {{8{inp_wgt[15]}}, inp_wgt};
    prod    = dat_ext * wgt_ext;
    acc_d   = acc_q + {{8{prod[23]}}, prod};
    rnd     = acc_d + 32'sd128;
    shifted = rnd >>> 8;
    if (shifted > 32'sd32767) begin
      sat = 16'h7fff;
    end else if (shifted < -32'sd32768) begin
      sat = 16'h8000;
    end else begin
      sat = shifted[15:0];
    end
    accept = (state_q == ST_ACC) && inp_rdy_q && inp_stb;
    last   = (cnt_q == CW'(ARGS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      cnt_q     <= '0;
      inp_rdy_q <= 1'b0;
      res_stb_q <= 1'b0;
      res_dat_q <= '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          inp_rdy_q <= 1'b1;
          if (accept) begin
            acc_q <= acc_d;
            if (last) begin
              res_dat_q <= sat;
              res_stb_q <= 1'b1;
              inp_rdy_q <= 1'b0;
              state_q   <= ST_OUT;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ST_OUT: begin
          if (res_rdy) begin
            res_stb_q <= 1'b0;
            inp_rdy_q <= 1'b1;
            acc_q     <= '0;
            cnt_q     <= '0;
            state_q   <= ST_ACC;
          end
        end
        default: state_q <= ST_ACC;
      endcase
    end
  end

  assign inp_rdy = inp_rdy_q;
  assign res_stb = res_stb_q;
  assign res_dat = res_dat_q;

endmodule

// File: tb/tb_dot_accumulate.sv
// Directed bench for dot_accumulate: an ARGS=4 instance for sums/handshake/reset
// and an ARGS=1 instance for rounding corner cases.
module tb_dot_accumulate;

  logic        clk;
  logic        rst;

  logic        a_stb, a_rdy, a_res_stb, a_res_rdy;
  logic [7:0]  a_dat;
  logic [15:0] a_wgt, a_res_dat;

  logic        b_stb, b_rdy, b_res_stb, b_res_rdy;
  logic [7:0]  b_dat;
  logic [15:0] b_wgt, b_res_dat;

  int checks = 0;
  int errors = 0;

  dot_accumulate #(.ARGS(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .inp_stb(a_stb), .inp_rdy(a_rdy), .inp_dat(a_dat), .inp_wgt(a_wgt),
    .res_stb(a_res_stb), .res_rdy(a_res_rdy), .res_dat(a_res_dat)
  );

  dot_accumulate #(.ARGS(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .inp_stb(b_stb), .inp_rdy(b_rdy), .inp_dat(b_dat), .inp_wgt(b_wgt),
    .res_stb(b_res_stb), .res_rdy(b_res_rdy), .res_dat(b_res_dat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Called at a falling edge; returns at the falling edge after the pair is consumed.
  task automatic push(input bit sel, input logic [7:0] d, input logic [15:0] w);
    int n;
    n = 0;
    if (sel) begin
      b_stb = 1'b1; b_dat = d; b_wgt = w;
      while (!b_rdy && n < 50) begin @(negedge clk); n++; end
      chk("push1_rdy", {31'b0, b_rdy}, 32'd1);
      @(negedge clk);
      b_stb = 1'b0;
    end else begin
      a_stb = 1'b1; a_dat = d; a_wgt = w;
      while (!a_rdy && n < 50) begin @(negedge clk); n++; end
      chk("push4_rdy", {31'b0, a_rdy}, 32'd1);
      @(negedge clk);
      a_stb = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b0;
    a_stb = 1'b0; a_dat = '0; a_wgt = '0; a_res_rdy = 1'b0;
    b_stb = 1'b0; b_dat = '0; b_wgt = '0; b_res_rdy = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_inp_rdy", {31'b0, a_rdy}, 32'd0);
    chk("rst_res_stb", {31'b0, a_res_stb}, 32'd0);
    chk("rst_res_dat", {16'b0, a_res_dat}, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_inp_rdy", {31'b0, a_rdy}, 32'd1);

    // Basic sum: 4 * 0.5 * 1.0 = 2.0
    a_res_rdy = 1'b1;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h80, 16'h0100);
    chk("basic_stb", {31'b0, a_res_stb}, 32'd1);
    chk("basic_dat", {16'b0, a_res_dat}, 32'h0200);
    chk("basic_rdy_lo", {31'b0, a_rdy}, 32'd0);
    @(negedge clk);
    chk("basic_stb_1cy", {31'b0, a_res_stb}, 32'd0);
    chk("basic_rdy_hi", {31'b0, a_rdy}, 32'd1);

    // Saturation
    for (int i = 0; i < 4; i++) push(1'b0, 8'hff, 16'h7fff);
    chk("satp_dat", {16'b0, a_res_dat}, 32'h7fff);
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1'b0, 8'hff, 16'h8000);
    chk("satn_dat", {16'b0, a_res_dat}, 32'h8000);
    @(negedge clk);

    // Backpressure with a held fifth pair
    a_res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h80, 16'h0100);
    a_stb = 1'b1; a_dat = 8'h80; a_wgt = 16'h0100;
    for (int i = 0; i < 10; i++) begin
      chk("bp_stb", {31'b0, a_res_stb}, 32'd1);
      chk("bp_dat", {16'b0, a_res_dat}, 32'h0200);
      chk("bp_rdy", {31'b0, a_rdy}, 32'd0);
      @(negedge clk);
    end
    a_res_rdy = 1'b1;
    @(negedge clk);
    chk("bp_taken", {31'b0, a_res_stb}, 32'd0);
    push(1'b0, 8'h80, 16'h0100);
    for (int i = 0; i < 2; i++) push(1'b0, 8'h80, 16'h0100);
    chk("bp_no_early", {31'b0, a_res_stb}, 32'd0);
    push(1'b0, 8'h80, 16'h0100);
    chk("bp2_stb", {31'b0, a_res_stb}, 32'd1);
    chk("bp2_dat", {16'b0, a_res_dat}, 32'h0200);
    @(negedge clk);

    // Gapped input: 4 * 0.25 * 4.0 = 4.0
    for (int i = 0; i < 4; i++) begin
      repeat (i) @(negedge clk);
      if (i == 3) chk("gap_no_early", {31'b0, a_res_stb}, 32'd0);
      push(1'b0, 8'h40, 16'h0400);
    end
    chk("gap_stb", {31'b0, a_res_stb}, 32'd1);
    chk("gap_dat", {16'b0, a_res_dat}, 32'h0400);
    @(negedge clk);

    // Reset mid-accumulation
    for (int i = 0; i < 2; i++) push(1'b0, 8'h80, 16'h0100);
    #2 rst = 1'b0;
    #1;
    chk("mrst_stb", {31'b0, a_res_stb}, 32'd0);
    chk("mrst_rdy", {31'b0, a_rdy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) push(1'b0, 8'h80, 16'hff00);
    chk("mrst_stb2", {31'b0, a_res_stb}, 32'd1);
    chk("mrst_dat", {16'b0, a_res_dat}, 32'hfe00);
    @(negedge clk);

    // Reset while a result is pending
    a_res_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push(1'b0, 8'h80, 16'h0100);
    chk("orst_pend", {31'b0, a_res_stb}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("orst_stb", {31'b0, a_res_stb}, 32'd0);
    chk("orst_dat", {16'b0, a_res_dat}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    a_res_rdy = 1'b1;
    @(negedge clk);

    // Rounding on the ARGS=1 instance
    b_res_rdy = 1'b1;
    push(1'b1, 8'h01, 16'h0080);
    chk("rnd_stb", {31'b0, b_res_stb}, 32'd1);
    chk("rnd_0080", {16'b0, b_res_dat}, 32'h0001);
    push(1'b1, 8'h01, 16'h007f);
    chk("rnd_007f", {16'b0, b_res_dat}, 32'h0000);
    push(1'b1, 8'h01, 16'hff80);
    chk("rnd_ff80", {16'b0, b_res_dat}, 32'h0000);
    push(1'b1, 8'h01, 16'hff7f);
    chk("rnd_ff7f", {16'b0, b_res_dat}, 32'hffff);
    push(1'b1, 8'h00, 16'h1234);
    chk("rnd_zero", {16'b0, b_res_dat}, 32'h0000);
    @(negedge clk);
    chk("rnd_stb_lo", {31'b0, b_res_stb}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
